// File: rtl/cnt_burst_sched.sv
// cnt_burst_sched: shares one up/down counter between two burst requesters.
//   A round-robin arbiter accepts one {dir, len} command while idle. The block
//   then emits one cnt_up or cnt_dn strobe per cycle until the burst is done.
//   Latency: accept at edge T, strobes in cycles T+1..T+len, done in cycle T+len
//   (len=0: done in T+1). Backpressure: ready is low while a burst runs, and a
//   global hold pauses strobes without losing the remaining count.
// Ports:
//   clk, rst_n (async, active-high: the block is in reset while rst_n=1)
//   req{0,1}_valid/dir/len/ready - command handshake per requester
//   hold      - pause strobes
//   cnt_value - counter value from the datapath (used only by the saturation guard)
//   cnt_up/cnt_dn - counter strobes
//   busy, grant_id, done, sat - status
// Optional feature: define CNT_BURST_SAT_GUARD_EN to end a burst early, with
//   done+sat, when the next strobe would make the counter wrap.
module cnt_burst_sched #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req0_dir,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_dir,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  input  logic             hold,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             cnt_up,
  output logic             cnt_dn,
  output logic             busy,
  output logic             grant_id,
  output logic             done,
  output logic             sat
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic             state;
  logic [LEN_W-1:0] remaining;
  logic             dir_r;
  logic             rr_ptr;
  logic             grant_q;

  logic is_run;
  logic accept;
  logic winner;
  logic rem_zero;
  logic rem_one;
  logic guard;
  logic strobe;

  assign is_run = (state == ST_RUN);

  // When both requesters are valid, rr_ptr chooses the winner. When only one
  // is valid, that requester wins. The two readys are mutually exclusive.
  assign req0_ready = ~is_run & req0_valid & (~req1_valid | ~rr_ptr);
  assign req1_ready = ~is_run & req1_valid & (~req0_valid |  rr_ptr);
  assign accept     = req0_ready | req1_ready;
  assign winner     = req1_ready;

  assign rem_zero = (remaining == '0);
  assign rem_one  = (remaining == LEN_W'(1));

`ifdef CNT_BURST_SAT_GUARD_EN
  // Stop before the counter would wrap. The guard also applies during hold,
  // so a held burst against a saturated counter still terminates.
  assign guard = is_run & (dir_r ? (&cnt_value) : ~(|cnt_value));
  assign sat   = guard;
`else
  logic unused_cnt_value;
  assign unused_cnt_value = ^cnt_value;
  assign guard = 1'b0;
  assign sat   = 1'b0;
`endif

  assign strobe   = is_run & ~rem_zero & ~hold & ~guard;
  assign cnt_up   = strobe &  dir_r;
  assign cnt_dn   = strobe & ~dir_r;
  assign busy     = is_run;
  assign grant_id = grant_q;
  // A len=0 burst ends in its first RUN cycle whatever the state of hold.
  assign done     = is_run & ((strobe & rem_one) | rem_zero | guard);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      dir_r     <= 1'b0;
      rr_ptr    <= 1'b0;
      grant_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_RUN;
            remaining <= winner ? req1_len : req0_len;
            dir_r     <= winner ? req1_dir : req0_dir;
            grant_q   <= winner;
            rr_ptr    <= ~winner;
          end
        end
        default: begin
          if (strobe) begin
            remaining <= remaining - LEN_W'(1);
          end
          if (done) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
